// File: rtl/fdc_pkg.sv
// Shared types and default widths for fetch_decode_sequencer and its interface.
package fdc_pkg;

  localparam int DEF_PC_W    = 16;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    UPDATE,
    DONE
  } fdc_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    HALT  = 2'd1,
    LIMIT = 2'd2
  } fdc_halt_e;

endpackage

// File: rtl/fdc_if.sv
// Top-level ap_ctrl_hs and fetch/decode sub-block signals of fetch_decode_sequencer.
// FDC_STALL_STATS_EN adds the fetch_stall/decode_stall counters.
interface fdc_if
  import fdc_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               ap_start;
  logic               ap_done;
  logic               ap_idle;
  logic               ap_ready;
  logic [PC_W-1:0]    start_pc;

  logic               fetch_start;
  logic               fetch_ready;
  logic               fetch_done;
  logic [PC_W-1:0]    fetch_pc;
  logic [INSTR_W-1:0] fetch_instr;

  logic               decode_start;
  logic               decode_ready;
  logic               decode_done;
  logic [INSTR_W-1:0] decode_instr;
  logic [PC_W-1:0]    decode_next_pc;
  logic               decode_halt;

  logic [CNT_W-1:0]   nbi;
  logic [1:0]         halt_reason;
`ifdef FDC_STALL_STATS_EN
  logic [CNT_W-1:0]   fetch_stall;
  logic [CNT_W-1:0]   decode_stall;
`endif

  // master is the sequencer; slave is the surrounding system and sub-blocks.
  modport master (
`ifdef FDC_STALL_STATS_EN
    output fetch_stall, decode_stall,
`endif
    input  ap_start, start_pc, fetch_ready, fetch_done, fetch_instr,
    input  decode_ready, decode_done, decode_next_pc, decode_halt,
    output ap_done, ap_idle, ap_ready, fetch_start, fetch_pc,
    output decode_start, decode_instr, nbi, halt_reason
  );

  modport slave (
`ifdef FDC_STALL_STATS_EN
    input  fetch_stall, decode_stall,
`endif
    output ap_start, start_pc, fetch_ready, fetch_done, fetch_instr,
    output decode_ready, decode_done, decode_next_pc, decode_halt,
    input  ap_done, ap_idle, ap_ready, fetch_start, fetch_pc,
    input  decode_start, decode_instr, nbi, halt_reason
  );

endinterface

// File: rtl/fdc_stage_hs.sv
// One ap_ctrl_hs stage: holds start until ready, reports completion on done.
module fdc_stage_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic i_phase_en,
  input  logic i_ready,
  input  logic i_done,
  output logic o_start,
  output logic o_finished
);

  logic r_issued;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_issued <= 1'b0;
    else if (!i_phase_en) r_issued <= 1'b0;
    else if (i_ready)     r_issued <= 1'b1;
  end

  // A done without a prior ready still ends the phase (combined ready+done).
  assign o_start    = i_phase_en && !r_issued;
  assign o_finished = i_phase_en && i_done;

endmodule

// File: rtl/fetch_decode_sequencer.sv
// Fetch -> decode -> update loop controller behind an ap_ctrl_hs interface.
// FDC_STALL_STATS_EN adds saturating fetch/decode stall-cycle counters.
module fetch_decode_sequencer
  import fdc_pkg::*;
#(
  parameter int          PC_W      = DEF_PC_W,
  parameter int          INSTR_W   = DEF_INSTR_W,
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int unsigned MAX_INSTR = 0
) (
  input  logic  ap_clk,
  input  logic  ap_rst_n,
  fdc_if.master bus
);

  fdc_state_e         r_state, w_next_state;
  fdc_halt_e          r_halt_reason;
  logic [PC_W-1:0]    r_pc, r_next_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_halt;
  logic [CNT_W-1:0]   r_nbi, w_nbi_inc;
  logic               w_accept, w_limit_hit;
  logic               w_in_fetch, w_in_decode;
  logic               w_fetch_finished, w_decode_finished;

  assign w_accept    = (r_state == IDLE) && bus.ap_start;
  assign w_in_fetch  = (r_state == FETCH);
  assign w_in_decode = (r_state == DECODE);
  assign w_nbi_inc   = (&r_nbi) ? r_nbi : r_nbi + CNT_W'(1);
  assign w_limit_hit = (MAX_INSTR != 0) && (w_nbi_inc == CNT_W'(MAX_INSTR));

  fdc_stage_hs u_fetch_hs (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .i_phase_en (w_in_fetch),
    .i_ready    (bus.fetch_ready),
    .i_done     (bus.fetch_done),
    .o_start    (bus.fetch_start),
    .o_finished (w_fetch_finished)
  );

  fdc_stage_hs u_decode_hs (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .i_phase_en (w_in_decode),
    .i_ready    (bus.decode_ready),
    .i_done     (bus.decode_done),
    .o_start    (bus.decode_start),
    .o_finished (w_decode_finished)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_next_state;
  end

  // NOTE: the default at the top of a combinational block prevents latch inference.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.ap_start)      w_next_state = FETCH;
      FETCH:   if (w_fetch_finished)  w_next_state = DECODE;
      DECODE:  if (w_decode_finished) w_next_state = UPDATE;
      UPDATE:  w_next_state = (r_halt || w_limit_hit) ? DONE : FETCH;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the captured data registers are reset too, since fetch_pc/decode_instr must read 0 after reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_pc          <= '0;
      r_next_pc     <= '0;
      r_instr       <= '0;
      r_halt        <= 1'b0;
      r_nbi         <= '0;
      r_halt_reason <= NONE;
    end else begin
      case (r_state)
        IDLE: if (bus.ap_start) begin
          r_pc          <= bus.start_pc;
          r_nbi         <= '0;
          r_halt_reason <= NONE;
        end
        FETCH: if (w_fetch_finished) r_instr <= bus.fetch_instr;
        DECODE: if (w_decode_finished) begin
          r_next_pc <= bus.decode_next_pc;
          r_halt    <= bus.decode_halt;
        end
        UPDATE: begin
          r_nbi <= w_nbi_inc;
          r_pc  <= r_next_pc;
          if (r_halt)           r_halt_reason <= HALT;
          else if (w_limit_hit) r_halt_reason <= LIMIT;
        end
        default: ;
      endcase
    end
  end

`ifdef FDC_STALL_STATS_EN
  logic [CNT_W-1:0] r_fetch_stall, r_decode_stall;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_fetch_stall  <= '0;
      r_decode_stall <= '0;
    end else if (w_accept) begin
      r_fetch_stall  <= '0;
      r_decode_stall <= '0;
    end else begin
      if (w_in_fetch && !bus.fetch_done && !(&r_fetch_stall))
        r_fetch_stall <= r_fetch_stall + CNT_W'(1);
      if (w_in_decode && !bus.decode_done && !(&r_decode_stall))
        r_decode_stall <= r_decode_stall + CNT_W'(1);
    end
  end

  assign bus.fetch_stall  = r_fetch_stall;
  assign bus.decode_stall = r_decode_stall;
`endif

  assign bus.ap_idle      = (r_state == IDLE);
  assign bus.ap_ready     = w_accept;
  assign bus.ap_done      = (r_state == DONE);
  assign bus.fetch_pc     = r_pc;
  assign bus.decode_instr = r_instr;
  assign bus.nbi          = r_nbi;
  assign bus.halt_reason  = r_halt_reason;

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Directed bench for fetch_decode_sequencer with latency-configurable fetch/decode models.
// Define FDC_STALL_STATS_EN to also exercise the stall counters.
module tb_fetch_decode_sequencer;

  localparam int PC_W      = 16;
  localparam int INSTR_W   = 32;
  localparam int CNT_W     = 32;
  localparam int MAX_INSTR = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fdc_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  fetch_decode_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .MAX_INSTR(MAX_INSTR)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Sub-block model configuration, written by the test tasks.
  int f_rdy_lat = 0, f_done_lat = 0, d_rdy_lat = 0, d_done_lat = 0, d_halt_at = 0;
  bit d_inject = 1'b0;

  // Monitor and model state, written only by the negedge process.
  int cyc = 0, n_ready = 0, n_done = 0, ready_cyc = 0, done_cyc = 0;
  int f_rises = 0, f_start_hi = 0, d_num = 0, f_cnt = 0, d_cnt = 0;
  bit f_start_q = 1'b0, f_active = 1'b0, d_active = 1'b0, d_mdl_done = 1'b0;
  logic [PC_W-1:0] pc_log [8];

  always @(negedge clk) begin
    cyc++;
    if (bus.ap_ready === 1'b1) begin
      n_ready++; ready_cyc = cyc; f_rises = 0; f_start_hi = 0; d_num = 0;
    end
    if (bus.ap_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (bus.fetch_start === 1'b1) begin
      f_start_hi++;
      if (!f_start_q) begin
        if (f_rises < 8) pc_log[f_rises] = bus.fetch_pc;
        f_rises++;
      end
    end
    f_start_q = (bus.fetch_start === 1'b1);

    if (!rst_n) begin
      f_active = 1'b0; d_active = 1'b0; d_mdl_done = 1'b0;
      bus.fetch_ready = 1'b0; bus.fetch_done = 1'b0; bus.decode_ready = 1'b0;
    end else begin
      if (f_active && bus.fetch_done) begin
        f_active = 1'b0; bus.fetch_ready = 1'b0; bus.fetch_done = 1'b0;
      end else begin
        if (!f_active && bus.fetch_start) begin f_active = 1'b1; f_cnt = 0; end
        else if (f_active) f_cnt++;
        bus.fetch_ready = f_active && (f_cnt == f_rdy_lat);
        bus.fetch_done  = f_active && (f_cnt == f_rdy_lat + f_done_lat);
      end
      if (d_active && d_mdl_done) begin
        d_active = 1'b0; d_mdl_done = 1'b0; bus.decode_ready = 1'b0;
      end else begin
        if (!d_active && bus.decode_start) begin d_active = 1'b1; d_cnt = 0; d_num++; end
        else if (d_active) d_cnt++;
        bus.decode_ready = d_active && (d_cnt == d_rdy_lat);
        d_mdl_done       = d_active && (d_cnt == d_rdy_lat + d_done_lat);
      end
    end
    // Off-cycle data is deliberately bogus so a mistimed capture shows up.
    bus.fetch_instr    = bus.fetch_done ? {16'hC0DE, bus.fetch_pc} : 32'hDEAD_BEEF;
    bus.decode_done    = d_mdl_done | d_inject;
    bus.decode_next_pc = d_mdl_done ? bus.decode_instr[15:0] + 16'd4 : 16'hDEAD;
    bus.decode_halt    = d_mdl_done ? ((d_halt_at != 0) && (d_num == d_halt_at)) : 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lat(input int fr, input int fd, input int dr, input int dd, input int halt_at);
    f_rdy_lat = fr; f_done_lat = fd; d_rdy_lat = dr; d_done_lat = dd; d_halt_at = halt_at;
  endtask

  task automatic start_run(input logic [PC_W-1:0] pc);
    tick();
    bus.start_pc = pc; bus.ap_start = 1'b1;
    #1;
    checks++; if (bus.ap_ready !== 1'b1) begin errors++; $display("FAIL start_ap_ready: got %b expected 1", bus.ap_ready); end
    tick();
    bus.ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = n_done;
    int k  = 0;
    while (n_done == n0 && k < budget) begin tick(); k++; end
    checks++; if (n_done == n0) begin errors++; $display("FAIL done_timeout: no ap_done within %0d cycles", budget); end
  endtask

  task automatic test_reset();
    bus.ap_start = 1'b0; bus.start_pc = '0; d_inject = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if ({bus.ap_idle, bus.ap_done, bus.ap_ready, bus.fetch_start, bus.decode_start} !== 5'b10000) begin
      errors++; $display("FAIL rst_flags: got %b expected 10000",
                         {bus.ap_idle, bus.ap_done, bus.ap_ready, bus.fetch_start, bus.decode_start}); end
    checks++; if ({bus.fetch_pc, bus.decode_instr, bus.nbi, bus.halt_reason} !== '0) begin
      errors++; $display("FAIL rst_values: got pc=%h instr=%h nbi=%0d hr=%0d expected all 0",
                         bus.fetch_pc, bus.decode_instr, bus.nbi, bus.halt_reason); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL rst_idle_after_release: got %b expected 1", bus.ap_idle); end
  endtask

  task automatic test_zero_latency();
    set_lat(0, 0, 0, 0, 3);
    start_run(16'h0010);
    wait_done(100);
    checks++; if (f_rises !== 3) begin errors++; $display("FAIL zl_fetch_count: got %0d expected 3", f_rises); end
    checks++; if (pc_log[0] !== 16'h0010) begin errors++; $display("FAIL zl_pc0: got %h expected 0010", pc_log[0]); end
    checks++; if (pc_log[1] !== 16'h0014) begin errors++; $display("FAIL zl_pc1: got %h expected 0014", pc_log[1]); end
    checks++; if (pc_log[2] !== 16'h0018) begin errors++; $display("FAIL zl_pc2: got %h expected 0018", pc_log[2]); end
    checks++; if (bus.nbi !== 32'd3) begin errors++; $display("FAIL zl_nbi: got %0d expected 3", bus.nbi); end
    checks++; if (bus.halt_reason !== 2'd1) begin errors++; $display("FAIL zl_halt_reason: got %0d expected 1", bus.halt_reason); end
    checks++; if (done_cyc - ready_cyc !== 10) begin errors++; $display("FAIL zl_latency: got %0d expected 10", done_cyc - ready_cyc); end
    checks++; if (bus.fetch_pc !== 16'h001C) begin errors++; $display("FAIL zl_final_pc: got %h expected 001c", bus.fetch_pc); end
    checks++; if (bus.decode_instr !== 32'hC0DE_0018) begin errors++; $display("FAIL zl_last_instr: got %h expected c0de0018", bus.decode_instr); end
    checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL zl_idle: got %b expected 1", bus.ap_idle); end
  endtask

  task automatic test_fetch_latency();
    set_lat(2, 3, 0, 0, 1);
    start_run(16'h0020);
    wait_done(100);
    checks++; if (f_start_hi !== 3) begin errors++; $display("FAIL fl_start_cycles: got %0d expected 3", f_start_hi); end
    checks++; if (f_rises !== 1) begin errors++; $display("FAIL fl_start_rises: got %0d expected 1", f_rises); end
    checks++; if (bus.decode_instr !== 32'hC0DE_0020) begin errors++; $display("FAIL fl_instr: got %h expected c0de0020", bus.decode_instr); end
    checks++; if (bus.nbi !== 32'd1) begin errors++; $display("FAIL fl_nbi: got %0d expected 1", bus.nbi); end
    checks++; if (done_cyc - ready_cyc !== 9) begin errors++; $display("FAIL fl_latency: got %0d expected 9", done_cyc - ready_cyc); end
  endtask

  task automatic test_limit();
    set_lat(0, 0, 0, 0, 0);
    start_run(16'h0100);
    wait_done(100);
    checks++; if (bus.nbi !== 32'd5) begin errors++; $display("FAIL lim_nbi: got %0d expected 5", bus.nbi); end
    checks++; if (bus.halt_reason !== 2'd2) begin errors++; $display("FAIL lim_halt_reason: got %0d expected 2", bus.halt_reason); end
    checks++; if (f_rises !== 5) begin errors++; $display("FAIL lim_fetch_count: got %0d expected 5", f_rises); end
    checks++; if (bus.fetch_pc !== 16'h0114) begin errors++; $display("FAIL lim_final_pc: got %h expected 0114", bus.fetch_pc); end
    checks++; if (done_cyc - ready_cyc !== 16) begin errors++; $display("FAIL lim_latency: got %0d expected 16", done_cyc - ready_cyc); end
  endtask

  task automatic test_back_to_back();
    int n_r0;
    int k = 0;
    set_lat(0, 0, 0, 0, 1);
    n_r0 = n_ready;
    tick();
    bus.start_pc = 16'h0200; bus.ap_start = 1'b1;
    while (bus.ap_done !== 1'b1 && k < 20) begin tick(); k++; end
    checks++; if (bus.ap_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", bus.ap_done); end
    tick();
    checks++; if ({bus.ap_idle, bus.ap_ready, bus.ap_done} !== 3'b110) begin
      errors++; $display("FAIL b2b_restart: got idle/ready/done=%b expected 110", {bus.ap_idle, bus.ap_ready, bus.ap_done}); end
    checks++; if (bus.nbi !== 32'd1) begin errors++; $display("FAIL b2b_nbi_hold: got %0d expected 1", bus.nbi); end
    tick();
    checks++; if ({bus.ap_idle, bus.fetch_start} !== 2'b01) begin
      errors++; $display("FAIL b2b_fetch: got idle/fetch_start=%b expected 01", {bus.ap_idle, bus.fetch_start}); end
    checks++; if (bus.nbi !== 32'd0) begin errors++; $display("FAIL b2b_nbi_clear: got %0d expected 0", bus.nbi); end
    bus.ap_start = 1'b0;
    wait_done(50);
    checks++; if (n_ready - n_r0 !== 2) begin errors++; $display("FAIL b2b_ready_pulses: got %0d expected 2", n_ready - n_r0); end
    checks++; if (bus.halt_reason !== 2'd1) begin errors++; $display("FAIL b2b_halt_reason: got %0d expected 1", bus.halt_reason); end
  endtask

  task automatic test_reset_mid_decode();
    int n_d0;
    int k = 0;
    set_lat(0, 0, 1, 20, 0);
    start_run(16'h0040);
    while (!(bus.decode_start === 1'b1 && bus.nbi === 32'd1) && k < 80) begin tick(); k++; end
    checks++; if (bus.decode_start !== 1'b1) begin errors++; $display("FAIL rmd_reach_decode: got %b expected 1", bus.decode_start); end
    checks++; if (bus.fetch_pc !== 16'h0044) begin errors++; $display("FAIL rmd_pc_before: got %h expected 0044", bus.fetch_pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.ap_idle, bus.ap_done, bus.ap_ready, bus.fetch_start, bus.decode_start} !== 5'b10000) begin
      errors++; $display("FAIL rmd_flags: got %b expected 10000",
                         {bus.ap_idle, bus.ap_done, bus.ap_ready, bus.fetch_start, bus.decode_start}); end
    checks++; if ({bus.fetch_pc, bus.decode_instr, bus.nbi, bus.halt_reason} !== '0) begin
      errors++; $display("FAIL rmd_values: got pc=%h instr=%h nbi=%0d hr=%0d expected all 0",
                         bus.fetch_pc, bus.decode_instr, bus.nbi, bus.halt_reason); end
    n_d0 = n_done;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    d_inject = 1'b1;
    tick();
    d_inject = 1'b0;
    repeat (3) tick();
    checks++; if ({bus.ap_idle, bus.fetch_start, bus.decode_start} !== 3'b100) begin
      errors++; $display("FAIL rmd_late_done_idle: got %b expected 100", {bus.ap_idle, bus.fetch_start, bus.decode_start}); end
    checks++; if ({bus.nbi, bus.decode_instr} !== '0) begin
      errors++; $display("FAIL rmd_late_done_regs: got nbi=%0d instr=%h expected 0", bus.nbi, bus.decode_instr); end
    checks++; if (n_done !== n_d0) begin errors++; $display("FAIL rmd_no_done: got %0d done pulses expected 0", n_done - n_d0); end
  endtask

`ifdef FDC_STALL_STATS_EN
  task automatic test_stall_stats();
    set_lat(0, 4, 0, 0, 2);
    start_run(16'h0300);
    wait_done(100);
    checks++; if (bus.fetch_stall !== 32'd8) begin errors++; $display("FAIL st_fetch_stall: got %0d expected 8", bus.fetch_stall); end
    checks++; if (bus.decode_stall !== 32'd0) begin errors++; $display("FAIL st_decode_stall: got %0d expected 0", bus.decode_stall); end
    checks++; if (bus.nbi !== 32'd2) begin errors++; $display("FAIL st_nbi: got %0d expected 2", bus.nbi); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_fetch_latency();
    test_limit();
    test_back_to_back();
    test_reset_mid_decode();
`ifdef FDC_STALL_STATS_EN
    test_stall_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
